fact_engine: RTL and testbench

Parametrised iterative factorial engine. It merges the factorial control sequencer and its datapath into one block, with configurable operand and result widths, a busy flag, a sticky overflow flag and a debug state output. A host pulses `go` with operand `n` and receives `n!` on `result`, qualified by a one-cycle `done`. It sits behind the GPIO/memory-mapped wrapper, where the factorial unit is used today.

---
 rtl/fact_engine.sv | 111 +++++++++++
 tb/tb_fact_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_engine.sv
// rtl/fact_engine.sv - iterative factorial engine; optional sticky overflow flag via FACT_OVF_DETECT_EN
module fact_engine #(
    parameter int N_W   = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [N_W-1:0]   n,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             ovf,
    output logic [2:0]       cs
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_MUL   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [N_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0] prod_lo;

`ifdef FACT_OVF_DETECT_EN
    logic [2*WIDTH-1:0] full;
    logic               ovf_q, ovf_d;

    // Double-width product so the upper half reveals a lost carry.
    assign full    = {{WIDTH{1'b0}}, product_q} * {{(2*WIDTH-N_W){1'b0}}, count_q};
    assign prod_lo = full[WIDTH-1:0];
    assign ovf     = ovf_q;
`else
    // Only the low half is kept; the product wraps silently.
    assign prod_lo = product_q * {{(WIDTH-N_W){1'b0}}, count_q};
    assign ovf     = 1'b0;
`endif

    assign result = product_q;
    assign done   = (state_q == S_DONE);
    assign busy   = (state_q == S_LOAD) || (state_q == S_CHECK) ||
                    (state_q == S_MUL)  || (state_q == S_DONE);
    assign cs     = state_q;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d   = state_q;
        product_d = product_q;
        count_d   = count_q;
`ifdef FACT_OVF_DETECT_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_LOAD;
            end
            S_LOAD: begin
                product_d = {{(WIDTH-1){1'b0}}, 1'b1};
                count_d   = n;
`ifdef FACT_OVF_DETECT_EN
                ovf_d     = 1'b0;
`endif
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                // count stops at 1, so the decrement in MUL never wraps.
                if (count_q <= N_W'(1)) state_d = S_DONE;
                else                    state_d = S_MUL;
            end
            S_MUL: begin
                product_d = prod_lo;
                count_d   = count_q - N_W'(1);
`ifdef FACT_OVF_DETECT_EN
                ovf_d     = ovf_q | (|full[2*WIDTH-1:WIDTH]);
`endif
                state_d   = S_CHECK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            product_q <= '0;
            count_q   <= '0;
`ifdef FACT_OVF_DETECT_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            product_q <= product_d;
            count_q   <= count_d;
`ifdef FACT_OVF_DETECT_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_fact_engine.sv
// tb/tb_fact_engine.sv - self-checking bench for fact_engine against a run-timeline model
module tb_fact_engine;

`ifdef FACT_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        go;
    logic [3:0]  n;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        ovf;
    logic [2:0]  cs;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit seen_mul = 0;

    // Model: k = cycles into the current run (0 = idle), L = edges from E0 to DONE.
    int          k        = 0;
    int          L        = 2;
    int          m_n      = 0;
    logic [31:0] last_res = '0;
    logic        last_ovf = 1'b0;

    fact_engine #(.N_W(4), .WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .n      (n),
        .result (result),
        .done   (done),
        .busy   (busy),
        .ovf    (ovf),
        .cs     (cs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Product of the first m terms of nn, nn-1, ... (exact for nn <= 15).
    function automatic longint unsigned partial(input int nn, input int m);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < m; i++) p = p * longint'(nn - i);
        return p;
    endfunction

    function automatic longint unsigned fact(input int nn);
        longint unsigned p;
        p = 1;
        for (int i = 2; i <= nn; i++) p = p * longint'(i);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural timeline of a run: LOAD, then n-1 (CHECK,MUL) pairs, final CHECK, DONE.
    always @(posedge clk or negedge rst) begin
        longint unsigned pf;
        if (!rst) begin
            k        = 0;
            last_res = '0;
            last_ovf = 1'b0;
        end else if (k == 0) begin
            if (go) k = 1;
        end else if (k == 1) begin
            m_n = int'(n);
            L   = 2 * ((m_n > 1) ? m_n : 1);
            k   = 2;
        end else if (k == L + 1) begin
            pf       = partial(m_n, (L - 1) / 2);
            last_res = pf[31:0];
            last_ovf = OVF_EN && (pf >= 64'h1_0000_0000);
            k        = 0;
        end else begin
            k = k + 1;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        int              ecs;
        logic [31:0]     eres;
        logic            eovf;
        longint unsigned p;
        if (k == 0)          ecs = 0;
        else if (k == 1)     ecs = 1;
        else if (k == L + 1) ecs = 4;
        else                 ecs = (k % 2 == 0) ? 2 : 3;
        if (k <= 1) begin
            eres = last_res;
            eovf = last_ovf;
        end else begin
            p    = partial(m_n, (k - 2) / 2);
            eres = p[31:0];
            eovf = OVF_EN && (p >= 64'h1_0000_0000);
        end
        chk("cs", cs, ecs);
        chk("busy", busy, (k != 0));
        chk("done", done, (k != 0) && (k == L + 1));
        chk("result", result, eres);
        chk("ovf", ovf, eovf);
        if (cs == 3'd3) seen_mul = 1;
        if (done) done_cnt++;
    end

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (cs == 3'd0 && !busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: timeout, cs=%0d required 0", cs);
        end
    endtask

    task automatic run(input int nv, input logic [31:0] er, input logic eo, input bit noise);
        int e0;
        int lat;
        bit got;
        wait_idle();
        @(posedge clk); #2;
        go = 1'b1;
        n = 4'(nv);
        seen_mul = 0;
        @(posedge clk); #1;
        e0 = cyc;
        #1 go = 1'b0;
        @(posedge clk); #2;
        n = 4'($urandom);
        if (noise) begin
            @(posedge clk); #2;
            go = 1'b1;
            n = 4'($urandom_range(0, 15));
            repeat (2) @(posedge clk);
            #2 go = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", got, 1);
        if (got) begin
            lat = cyc - e0;
            chk("latency", lat, 2 * ((nv > 1) ? nv : 1));
            chk("run_result", result, er);
            chk("run_ovf", ovf, eo);
            if (nv <= 1) chk("no_mul_state", seen_mul, 0);
            @(negedge clk);
            chk("cs_after_done", cs, 0);
        end
    endtask

    initial begin
        longint unsigned f;
        int              nv;
        int              dc0;
        bit              got;

        rst = 1'b0;
        go  = 1'b0;
        n   = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_result", result, 0);
        chk("rst_cs", cs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b1;

        run(5, 32'd120, 1'b0, 1'b0);
        run(0, 32'd1, 1'b0, 1'b0);
        run(1, 32'd1, 1'b0, 1'b0);
        run(12, 32'd479001600, 1'b0, 1'b0);
        run(13, 32'd1932053504, OVF_EN, 1'b0);
        run(7, 32'd5040, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a multiply.
        wait_idle();
        @(posedge clk); #2;
        go = 1'b1;
        n = 4'd9;
        @(posedge clk); #2;
        go = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_cs", cs, 0);
        chk("abort_result", result, 0);
        chk("abort_busy", busy, 0);
        dc0 = done_cnt;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt, dc0);
        run(4, 32'd24, 1'b0, 1'b0);

        // go held high: back-to-back runs with one IDLE cycle between them.
        wait_idle();
        @(posedge clk); #2;
        go = 1'b1;
        n = 4'd3;
        for (int r = 0; r < 3; r++) begin
            got = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) begin
                    got = 1;
                    break;
                end
            end
            chk("held_done_seen", got, 1);
            chk("held_result", result, 6);
            @(negedge clk);
            chk("held_idle_gap", cs, 0);
            chk("held_single_done", done, 0);
            @(negedge clk);
            chk("held_restart", cs, 1);
        end
        go = 1'b0;

        // Randomized operands, with go/n noise during longer runs.
        for (int t = 0; t < 24; t++) begin
            nv = $urandom_range(0, 15);
            f  = fact(nv);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run(nv, f[31:0], OVF_EN && (f >= 64'h1_0000_0000), (nv >= 3) && ($urandom_range(0, 1) == 1));
        end

        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
